// File: rtl/regfile_pkg.sv
// Shared types and constants for the GenshinMIPS general-purpose register file.
// This package replaces the legacy define file (RegBus, RegAddrBus, enables, reset levels).
package regfile_pkg;

   localparam int REG_NUM      = 32;
   localparam int REG_NUM_LOG2 = 5;
   localparam int REG_W        = 32;

   typedef logic [REG_NUM_LOG2-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]        reg_data_t;

   localparam reg_data_t ZERO_WORD    = '0;
   localparam reg_addr_t NOP_REG_ADDR = '0;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic READ_ENABLE   = 1'b1;
   localparam logic READ_DISABLE  = 1'b0;
   localparam logic RST_ENABLE    = 1'b0;
   localparam logic RST_DISABLE   = 1'b1;

   // Write-back request as delivered by the MEM/WB pipeline register.
   typedef struct packed {
      logic      we;
      reg_addr_t waddr;
      reg_data_t wdata;
   } wb_req_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset, enable and $0 priority, then optional
// write-first bypass (REGFILE_BYPASS_EN), then the array word selected by the top.
module regfile_rd_port
   import regfile_pkg::*;
(
   input  logic      rst,
   input  logic      re,
   input  reg_addr_t raddr,
   input  reg_data_t word,
   input  wb_req_t   wb,
   output reg_data_t rdata
);

   logic w_bypass_hit;

`ifdef REGFILE_BYPASS_EN
   assign w_bypass_hit = (wb.we == WRITE_ENABLE) && (wb.waddr == raddr);
`else
   logic w_unused_wb;
   assign w_bypass_hit = 1'b0;
   assign w_unused_wb  = ^wb;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      rdata = ZERO_WORD;
      if (rst == RST_ENABLE) begin
         rdata = ZERO_WORD;
      end else if (re == READ_DISABLE) begin
         rdata = ZERO_WORD;
      end else if (raddr == NOP_REG_ADDR) begin
         rdata = ZERO_WORD;
      end else if (w_bypass_hit) begin
         rdata = wb.wdata;
      end else begin
         rdata = word;
      end
   end

endmodule

// File: rtl/regfile.sv
// GenshinMIPS register file: 31 storage words plus hardwired $0, one write port,
// two combinational read ports. Define REGFILE_BYPASS_EN for same-cycle write-first reads.
module regfile
   import regfile_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      we,
   input  reg_addr_t waddr,
   input  reg_data_t wdata,
   input  logic      re1,
   input  reg_addr_t raddr1,
   output reg_data_t rdata1,
   input  logic      re2,
   input  reg_addr_t raddr2,
   output reg_data_t rdata2
);

   reg_data_t r_regs [1:REG_NUM-1];
   wb_req_t   w_wb;
   reg_data_t w_word1;
   reg_data_t w_word2;

   assign w_wb = '{we: we, waddr: waddr, wdata: wdata};

   // NOTE: the array is cleared by reset because reads of unwritten registers must be 0, not X.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         for (int i = 1; i < REG_NUM; i++) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_regs[i] <= ZERO_WORD;
         end
      end else if (we == WRITE_ENABLE && waddr != NOP_REG_ADDR) begin
         r_regs[waddr] <= wdata;
      end
   end

   // Index 0 has no storage; the port masks it anyway, this just keeps the select in range.
   assign w_word1 = (raddr1 == NOP_REG_ADDR) ? ZERO_WORD : r_regs[raddr1];
   assign w_word2 = (raddr2 == NOP_REG_ADDR) ? ZERO_WORD : r_regs[raddr2];

   regfile_rd_port u_rd_port1 (
      .rst   (rst),
      .re    (re1),
      .raddr (raddr1),
      .word  (w_word1),
      .wb    (w_wb),
      .rdata (rdata1)
   );

   regfile_rd_port u_rd_port2 (
      .rst   (rst),
      .re    (re2),
      .raddr (raddr2),
      .word  (w_word2),
      .wb    (w_wb),
      .rdata (rdata2)
   );

endmodule
